hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/riscv_pipe_pkg.sv | 29 ++
 rtl/forward_unit.sv | 29 ++
 rtl/hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pipe_pkg : shared hazard-control types and forward-select encodings
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // x0 is hard-wired zero, so a write to it never produces a hazard.
  function automatic logic reg_hit(input logic we,
                                   input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

`default_nettype wire

// File: rtl/forward_unit.sv
// ---------------------------------------------------------------------------
// forward_unit : ALU operand bypass select for one Execute source register
// ---------------------------------------------------------------------------
`default_nettype none

module forward_unit
  import riscv_pipe_pkg::*;
(
  input  logic [REG_W-1:0] rsnE,
  input  logic [REG_W-1:0] rdnM,
  input  logic [REG_W-1:0] rdnW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  output logic [1:0]       fwd_sel
);

  // Memory stage holds the younger result, so it wins over Writeback.
  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_hit(RegWriteM, rdnM, rsnE)) begin
      fwd_sel = FWD_MEM;
    end else if (reg_hit(RegWriteW, rdnW, rsnE)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl : pipeline stall/flush/forward control with data-memory wait FSM
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  rs1nD,
  input  logic [REG_W-1:0]  rs2nD,
  input  logic [REG_W-1:0]  rs1nE,
  input  logic [REG_W-1:0]  rs2nE,
  input  logic [REG_W-1:0]  rdnE,
  input  logic [REG_W-1:0]  rdnM,
  input  logic [REG_W-1:0]  rdnW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              mem_err,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_e          state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic [PERF_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic               mem_start;
  logic               mem_stall;
  logic               branch;
  logic               load_use;
  logic               stall_f, stall_d, stall_e, stall_m;
  logic               flush_d, flush_e;
  logic               wait_expired;
  logic [1:0]         fwd_a, fwd_b;

  forward_unit u_fwd_a (
    .rsnE      (rs1nE),
    .rdnM      (rdnM),
    .rdnW      (rdnW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .fwd_sel   (fwd_a)
  );

  forward_unit u_fwd_b (
    .rsnE      (rs2nE),
    .rdnM      (rdnM),
    .rdnW      (rdnW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .fwd_sel   (fwd_b)
  );

  // The triggering RUN cycle already freezes the pipe so the request stays put.
  always_comb begin
    mem_start = (state_q == RUN) && MemReqM && !MemReadyM;
    mem_stall = mem_start || (state_q != RUN);
    branch    = (state_q == RUN) && PCSrcE;
    load_use  = (state_q == RUN) && ResultSrcE && RegWriteE && (rdnE != '0) &&
                ((rdnE == rs1nD) || (rdnE == rs2nD));
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (branch) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    StallF    = rst & stall_f;
    StallD    = rst & stall_d;
    StallE    = rst & stall_e;
    StallM    = rst & stall_m;
    FlushD    = rst & flush_d;
    FlushE    = rst & flush_e;
    ForwardAE = rst ? fwd_a : FWD_RF;
    ForwardBE = rst ? fwd_b : FWD_RF;
    mem_err   = mem_err_q;
    stall_cnt = stall_cnt_q;
  end

  // Timeout fires when this wait cycle brings the count up to MEM_TIMEOUT.
  always_comb begin
    wait_expired = ({1'b0, wait_cnt_q} + {{WAIT_W{1'b0}}, 1'b1}) >= {1'b0, WAIT_MAX};
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      RUN: begin
        if (mem_start) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (MemReadyM) begin
          state_d = RUN;
        end else if (wait_expired) begin
          state_d   = ERROR;
          mem_err_d = 1'b1;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (stall_f && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl : table vectors plus memory-wait/timeout sequences, scoreboarded
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_PERF_W  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1nD, rs2nD, rs1nE, rs2nE, rdnE, rdnM, rdnW;
  logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       mem_err;
  logic [TB_PERF_W-1:0] stall_cnt;

  hazard_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .PERF_W(TB_PERF_W)) dut (
    .clk(clk), .rst(rst),
    .rs1nD(rs1nD), .rs2nD(rs2nD), .rs1nE(rs1nE), .rs2nE(rs2nE),
    .rdnE(rdnE), .rdnM(rdnM), .rdnW(rdnW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_sc = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string      name;
    logic [4:0] d1, d2, e1, e2, rde, rdm, rdw;
    logic       rwe, rwm, rww, rsrc, pcs;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[14];

  // Packs {StallF,StallD,StallE,StallM,FlushD,FlushE,ForwardAE,ForwardBE}.
  function automatic logic [31:0] mk(input bit sf, input bit sd, input bit se, input bit sm,
                                     input bit fd, input bit fe,
                                     input logic [1:0] fa, input logic [1:0] fb);
    return {22'd0, sf, sd, se, sm, fd, fe, fa, fb};
  endfunction

  function automatic logic [31:0] outs();
    return {22'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE};
  endfunction

  function automatic vec_t mkv(input string name,
                               input logic [4:0] d1, input logic [4:0] d2,
                               input logic [4:0] e1, input logic [4:0] e2,
                               input logic [4:0] rde, input logic [4:0] rdm, input logic [4:0] rdw,
                               input logic rwe, input logic rwm, input logic rww,
                               input logic rsrc, input logic pcs, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.d1 = d1; v.d2 = d2; v.e1 = e1; v.e2 = e2;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw;
    v.rwe = rwe; v.rwm = rwm; v.rww = rww; v.rsrc = rsrc; v.pcs = pcs; v.exp = exp;
    return v;
  endfunction

  task automatic expect_val(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic compare(input logic [31:0] act);
    sb_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty actual=%0h", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s actual=%0h required=%0h", e.name, act, e.exp);
      end
    end
  endtask

  // Expected StallF=1 means the counter bumps on the edge that ends this cycle.
  task automatic expect_outs(input string name, input logic [31:0] exp);
    expect_val(name, exp);
    if (exp[9]) exp_sc++;
  endtask

  task automatic clear_in();
    rs1nD = '0; rs2nD = '0; rs1nE = '0; rs2nE = '0;
    rdnE = '0; rdnM = '0; rdnW = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    ResultSrcE = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic apply(input vec_t v);
    clear_in();
    rs1nD = v.d1; rs2nD = v.d2; rs1nE = v.e1; rs2nE = v.e2;
    rdnE = v.rde; rdnM = v.rdm; rdnW = v.rdw;
    RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww;
    ResultSrcE = v.rsrc; PCSrcE = v.pcs;
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ALL_STALL, LU, BR, IDLE;
  bit seen;

  initial begin
    ALL_STALL = mk(1, 1, 1, 1, 0, 0, 2'b00, 2'b00);
    LU        = mk(1, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    BR        = mk(0, 0, 0, 0, 1, 1, 2'b00, 2'b00);
    IDLE      = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00);

    vecs[0]  = mkv("idle",        0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, IDLE);
    vecs[1]  = mkv("lu_rs1",      5, 0, 0, 0, 5, 0, 0,  1, 0, 0, 1, 0, LU);
    vecs[2]  = mkv("lu_branch",   5, 0, 0, 0, 5, 0, 0,  1, 0, 0, 1, 1, BR);
    vecs[3]  = mkv("lu_rs2",      3, 5, 0, 0, 5, 0, 0,  1, 0, 0, 1, 0, LU);
    vecs[4]  = mkv("lu_x0",       0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, IDLE);
    vecs[5]  = mkv("lu_no_we",    5, 0, 0, 0, 5, 0, 0,  0, 0, 0, 1, 0, IDLE);
    vecs[6]  = mkv("lu_not_load", 5, 0, 0, 0, 5, 0, 0,  1, 0, 0, 0, 0, IDLE);
    vecs[7]  = mkv("branch",      0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, BR);
    vecs[8]  = mkv("fwd_mem_a",   0, 0, 7, 0, 0, 7, 7,  0, 1, 1, 0, 0, mk(0,0,0,0,0,0,2'b10,2'b00));
    vecs[9]  = mkv("fwd_rs_x0",   0, 0, 0, 0, 0, 7, 7,  0, 1, 1, 0, 0, IDLE);
    vecs[10] = mkv("fwd_wb_b",    0, 0, 0, 9, 0, 9, 9,  0, 0, 1, 0, 0, mk(0,0,0,0,0,0,2'b00,2'b01));
    vecs[11] = mkv("fwd_split",   0, 0, 6, 4, 0, 4, 6,  0, 1, 1, 0, 0, mk(0,0,0,0,0,0,2'b01,2'b10));
    vecs[12] = mkv("fwd_rd_x0",   0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, IDLE);
    vecs[13] = mkv("lu_and_fwd",  0, 8, 8, 0, 8, 8, 0,  1, 1, 0, 1, 0, mk(1,1,0,0,0,1,2'b10,2'b00));

    // Reset held with every hazard input active: outputs must stay quiet.
    rst = 1'b0;
    clear_in();
    rs1nD = 5; rdnE = 5; RegWriteE = 1; ResultSrcE = 1; PCSrcE = 1;
    rs1nE = 7; rs2nE = 7; rdnM = 7; RegWriteM = 1; MemReqM = 1;
    repeat (2) @(negedge clk);
    expect_val("reset_outs", IDLE);
    expect_val("reset_mem_err", 32'd0);
    expect_val("reset_stall_cnt", 32'd0);
    compare(outs());
    compare({31'd0, mem_err});
    compare({16'd0, stall_cnt});

    next_drive();
    rst = 1'b1;
    clear_in();

    // Single-cycle load-use, then counter shows exactly one stalled cycle.
    next_drive();
    apply(vecs[1]);
    expect_outs("lu_single", LU);
    @(negedge clk);
    compare(outs());
    next_drive();
    clear_in();
    expect_outs("lu_release", IDLE);
    expect_val("lu_stall_cnt", 32'd1);
    @(negedge clk);
    compare(outs());
    compare({16'd0, stall_cnt});

    for (int i = 0; i < 14; i++) begin
      next_drive();
      apply(vecs[i]);
      expect_outs(vecs[i].name, vecs[i].exp);
      @(negedge clk);
      compare(outs());
    end
    next_drive();
    clear_in();
    expect_val("table_stall_cnt", 32'(exp_sc));
    @(negedge clk);
    compare({16'd0, stall_cnt});

    // Three not-ready cycles then ready, with a branch waiting in Execute.
    for (int t = 0; t < 5; t++) begin
      next_drive();
      clear_in();
      PCSrcE    = 1;
      MemReqM   = (t < 4);
      MemReadyM = (t == 3);
      expect_outs($sformatf("memwait_t%0d", t), (t < 4) ? ALL_STALL : BR);
      if (t == 4) expect_val("memwait_stall_cnt", 32'(exp_sc));
      @(negedge clk);
      compare(outs());
      if (t == 4) compare({16'd0, stall_cnt});
    end

    // Memory never answers: must time out into ERROR.
    next_drive();
    clear_in();
    MemReqM = 1;
    expect_outs("timeout_entry", ALL_STALL);
    @(negedge clk);
    compare(outs());
    repeat (2) @(negedge clk);
    expect_val("mem_err_early", 32'd0);
    compare({31'd0, mem_err});
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (mem_err) seen = 1;
    end
    expect_val("mem_err_set", 32'd1);
    compare({31'd0, mem_err});

    next_drive();
    clear_in();
    MemReadyM = 1;
    PCSrcE    = 1;
    expect_val("error_stall", ALL_STALL);
    @(negedge clk);
    compare(outs());

    // Asynchronous reset pulse mid-cycle clears ERROR.
    #2;
    rst = 1'b0;
    #1;
    expect_val("rst_pulse_mem_err", 32'd0);
    expect_val("rst_pulse_stall_cnt", 32'd0);
    expect_val("rst_pulse_outs", IDLE);
    compare({31'd0, mem_err});
    compare({16'd0, stall_cnt});
    compare(outs());
    next_drive();
    rst = 1'b1;
    exp_sc = 0;
    clear_in();
    expect_outs("post_rst_idle", IDLE);
    @(negedge clk);
    compare(outs());
    next_drive();
    apply(vecs[1]);
    expect_outs("post_rst_run_lu", LU);
    @(negedge clk);
    compare(outs());
    next_drive();
    clear_in();
    expect_val("post_rst_stall_cnt", 32'(exp_sc));
    @(negedge clk);
    compare({16'd0, stall_cnt});

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
